param_stream_sink: RTL
======================

# param_stream_sink

Receiving end of the parameter-stream interface. It accepts `IN_DEPTH` beats of `IN_SIZE`-element vectors over a valid/ready handshake, such as bias or weight blocks emitted by a parameter source. Each beat is packed into one word of an internal buffer. The stored blocks are then served through a ROM-style, two-cycle-latency read port (`address0`/`ce0`/`q0`). The block sits between a streaming parameter producer and any consumer that needs random access to the parameter block.

## Interface
- `IN_SIZE`, 32, elements per beat
- `IN_WIDTH`, 16, bits per element
- `IN_DEPTH`, 8, beats per full parameter block (buffer depth)
- `ADDR_WIDTH`, `$clog2(IN_DEPTH)+1`, read address width (derived, localparam)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `data_in`  in  `IN_WIDTH` x `[IN_SIZE-1:0]`  unpacked element array, one beat
- `data_in_valid`  in  1  beat present
- `data_in_ready`  out  1  sink accepts beat
- `reload`  in  1  single-cycle pulse; restart loading from beat 0
- `loaded`  out  1  full block captured, buffer readable
- `address0`  in  `ADDR_WIDTH`  read address (beat index)
- `ce0`  in  1  read pipeline enable
- `q0`  out  `IN_WIDTH*IN_SIZE`  packed read data

## Operation
- Packing: element j occupies bits `[IN_WIDTH*j+IN_WIDTH-1 : IN_WIDTH*j]` of the buffer word. Element 0 is in the LSBs.
- A beat transfers on a rising edge when `data_in_valid && data_in_ready`. It is written to `mem[wr_ptr]`.
- `wr_ptr` has width `$clog2(IN_DEPTH)+1` and resets to 0.
- FSM states: LOAD and HOLD.
  - LOAD:
    - `data_in_ready`=1.
    - Each transfer increments `wr_ptr`.
    - A transfer with `wr_ptr==IN_DEPTH-1` sets `wr_ptr` to 0, enters HOLD, sets `loaded`=1 and clears `data_in_ready`. All of these are registered and visible the next cycle.
  - HOLD:
    - `data_in_ready`=0 (see Configuration).
    - `loaded`=1.
    - The buffer is stable.
  - `reload` from any state: next state LOAD, `wr_ptr`=0, `loaded`=0, `data_in_ready`=1.
    - `reload` has priority: a beat transferring in the same cycle is discarded and not written.
- Read port:
  - The read port operates in both states.
  - Stage 0 (if `ce0`): `rd_q <= (address0 < IN_DEPTH) ? mem[address0] : 0`.
  - Stage 1 (if `ce0`): `q0 <= rd_q`.
  - `ce0`=0 freezes both stages.
- A same-cycle read and write to the same address is read-before-write: stage 0 captures the old word.
- Reads during LOAD return whatever the buffer currently holds. Unwritten words return undefined data; the buffer is not reset.

## Timing
- Reset values: `data_in_ready`=0, `loaded`=0, `q0`=0, stage-0 register=0, `wr_ptr`=0, state=LOAD.
- `data_in_ready` is registered. It rises on the first rising edge after `rst_n` deasserts.
- Asserting `rst_n` low mid-load aborts the load immediately. No partial `loaded` is reported.
- The written word is readable in stage 0 one cycle after its transfer edge.
- Read latency: 2 `ce0`-enabled edges from `address0` to `q0`.
- Throughput: one beat per cycle. A full block of `IN_DEPTH` beats loads in `IN_DEPTH` cycles minimum.
- `loaded` rises on the cycle after the final transfer edge.
- `data_in_valid` low stalls loading with no state change.

## Configuration
- Macro: `PARAM_STREAM_SINK_WRAP_EN`.
- Defined: HOLD keeps `data_in_ready`=1.
  - Further transfers overwrite `mem[wr_ptr]` cyclically: `wr_ptr` wraps at `IN_DEPTH-1` to 0.
  - `loaded` stays 1.
  - This matches a source that streams its block repeatedly with `data_in_valid` tied high.
- Undefined: HOLD rejects beats (`data_in_ready`=0) until `reload`.

## Test plan
- Reset then 8 back-to-back beats, with beat k element j = 16*k+j (`IN_SIZE`=32, `IN_WIDTH`=16, `IN_DEPTH`=8):
  - `loaded` rises 1 cycle after the 8th transfer.
  - Reading `address0`=3 gives `q0` element j = 48+j, 2 cycles later.
- Random `data_in_valid` gaps:
  - The same 8 beats are stored in order.
  - `wr_ptr` advances only on transfers.
- `reload` pulsed together with a valid beat 5 in LOAD:
  - That beat is not written.
  - The next accepted beat lands at address 0.
  - `loaded`=0 until 8 more transfers.
- `address0`=8 and `address0`=15 with `ce0`=1: `q0`=0. Holding `ce0`=0 for 3 cycles: `q0` is unchanged.
- `rst_n` pulled low asynchronously after 4 beats:
  - `data_in_ready`, `loaded` and `q0` go 0 immediately.
  - After release, 8 beats are needed to reach `loaded`.
- With `PARAM_STREAM_SINK_WRAP_EN`, stream 10 beats: words 0 and 1 hold beats 8 and 9, and `loaded` stays 1. Without the macro, `data_in_ready`=0 after beat 8.

Source files
------------

// File: rtl/param_stream_sink.sv
// param_stream_sink: buffers one block of streamed parameter beats and serves it through a two-cycle ROM-style read port.
// Optional build macro PARAM_STREAM_SINK_WRAP_EN keeps accepting beats after the block is full, overwriting it cyclically.
module param_stream_sink #(
    parameter int IN_SIZE  = 32,
    parameter int IN_WIDTH = 16,
    parameter int IN_DEPTH = 8,
    localparam int ADDR_WIDTH = $clog2(IN_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [IN_WIDTH-1:0]          data_in [IN_SIZE],
    input  logic                         data_in_valid,
    output logic                         data_in_ready,
    input  logic                         reload,
    output logic                         loaded,
    input  logic [ADDR_WIDTH-1:0]        address0,
    input  logic                         ce0,
    output logic [IN_WIDTH*IN_SIZE-1:0]  q0
);
    localparam int PW = $clog2(IN_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(IN_DEPTH - 1);
`ifdef PARAM_STREAM_SINK_WRAP_EN
    localparam logic HOLD_READY = 1'b1;
`else
    localparam logic HOLD_READY = 1'b0;
`endif

    typedef enum logic {LOAD, HOLD} state_e;

    state_e                        state_q;
    logic [ADDR_WIDTH-1:0]         wr_ptr_q, wr_ptr_d;
    logic                          ready_q, loaded_q, xfer;
    logic [IN_WIDTH*IN_SIZE-1:0]   wr_word, rd_q;
    logic [IN_WIDTH*IN_SIZE-1:0]   mem [IN_DEPTH];

    for (genvar j = 0; j < IN_SIZE; j++) begin : g_pack
        assign wr_word[IN_WIDTH*j +: IN_WIDTH] = data_in[j];
    end

    assign xfer          = data_in_valid && ready_q;
    assign wr_ptr_d      = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    assign data_in_ready = ready_q;
    assign loaded        = loaded_q;

    // Load/hold control; reload wins over any beat offered in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
            ready_q  <= 1'b0;
            loaded_q <= 1'b0;
        end else if (reload) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
            ready_q  <= 1'b1;
            loaded_q <= 1'b0;
        end else if (state_q == LOAD) begin
            ready_q <= 1'b1;
            if (xfer) begin
                wr_ptr_q <= wr_ptr_d;
                if (wr_ptr_q == LAST) begin
                    state_q  <= HOLD;
                    loaded_q <= 1'b1;
                    ready_q  <= HOLD_READY;
                end
            end
        end else if (xfer) begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Beat storage; deliberately unreset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (xfer && !reload) mem[wr_ptr_q[PW-1:0]] <= wr_word;
    end

    // Two-stage read pipeline, frozen while ce0 is low; out-of-range addresses read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
            q0   <= '0;
        end else if (ce0) begin
            rd_q <= (address0 < ADDR_WIDTH'(IN_DEPTH)) ? mem[address0[PW-1:0]] : '0;
            q0   <= rd_q;
        end
    end
endmodule
